osbm_arb: RTL and testbench
===========================

Name: osbm_arb

Overview:
- Output-side arbiter for one switch output port; the counterpart of the input-side request/transfer manager in each input port.
- Takes one request bit from each input port and grants exactly one input at a time with round-robin priority.
- Forwards the granted input's flits onto the output link until a TAIL flit passes, then releases the port.
- One instance per output port; flit-type encodings (`HEAD/`BODY/`TAIL) and `ASSERT/`NEGATE come from sw/sw.vh.

Parameters:
- NIN, 4, number of input ports (equal to `PORT+1).
- DW, 16, flit payload width in bits.
- IW, 2, width of owner index; must satisfy 2**IW >= NIN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NIN  bit i = input i requests this output (this output's bit of that input's req vector).
- ack  out  NIN  bit i = grant to input i; input i pops its head flit in the same cycle.
- empty  in  NIN  bit i = input i FIFO empty.
- din  in  NIN*DW  input i payload at bits [i*DW +: DW], first-word-fall-through.
- tin  in  NIN*2  input i flit type at bits [i*2 +: 2].
- dout  out  DW  registered output payload.
- tout  out  2  registered output flit type.
- vout  out  1  registered output valid.
- busy  out  1  a packet currently owns the port (state XFER).
- owner  out  IW  index of the current owner; meaningful only while busy.

Behaviour:
- Reset (async): state=INIT, prio pointer=0, owner=0, vout=0, dout=0, tout=0, ack=0.
- INIT:
  - ack is combinational. If req!=0, win = first i with req[i]=1, scanning prio, prio+1, ... mod NIN; ack = one-hot(win). Otherwise ack=0.
  - Grant cycle: owner<=win. Capture the flit if empty[win]=0.
  - If the captured flit type is `TAIL (single-flit packet), stay in INIT and set prio<=(win+1) mod NIN.
  - Otherwise go to XFER.
- XFER:
  - ack=0 for all inputs; new requests are ignored, and the owner's req is held by the requester.
  - Capture the owner's flit each cycle that empty[owner]=0.
  - On capturing a `TAIL flit: next state INIT, prio<=(owner+1) mod NIN.
- Capture:
  - dout<=din[owner slice], tout<=tin[owner slice], vout<=1 on the next edge (latency 1 cycle).
  - In any cycle without a capture, vout<=0. dout and tout hold their values.
- No backpressure on the output link: one flit per cycle maximum, throughput 1 flit/cycle.
- An empty owner FIFO in XFER produces bubbles (vout=0) and no state change.
- Owner dropping req in XFER has no effect; only `TAIL ends ownership.
- The pointer advances only on packet completion, never on grant.
- Grant-cycle flits of type `BODY or `TAIL without a preceding `HEAD are forwarded as-is; the arbiter does no framing check.
- busy=1 exactly in XFER. In INIT, owner still shows the last owner.
- Reset asserted mid-packet: immediate return to INIT, vout=0, in-flight packet truncated. The first request after reset is arbitrated from prio=0.
- State encoding: 1 bit using `INIT/`XFER.

Test Plan:
- Reset, then req=4'b0001 with input 0 holding HEAD,BODY,BODY,TAIL (data 0x10..0x13) -> ack=0001 in cycle 0 only. vout=1 for 4 consecutive cycles starting cycle 1, dout 0x10..0x13, tout HEAD..TAIL. busy falls after TAIL is captured.
- req=4'b1111 held continuously, each input sends 2-flit packets -> grants in order 0,1,2,3,0. No two acks ever set simultaneously. No interleaving of flits between packets.
- Owner input 2, empty[2]=1 for 3 cycles mid-packet -> vout=0 for those 3 cycles. busy stays 1. ack=0 despite req=4'b1011.
- Single-flit packet (type `TAIL) on input 3 with prio=3 -> ack=1000 for 1 cycle. busy never rises. Next winner among req=4'b1001 is input 0.
- Async rst pulse mid-XFER (between clock edges) -> vout, busy and ack drop without waiting for clk. The next request from input 1 is granted by prio=0 scan.
- Simultaneous TAIL capture and new req from another input in the same cycle -> new ack appears only in the following cycle, after return to INIT.

Source files
------------

// File: rtl/osbm_arb.sv
// Output-side arbiter for one switch output port: round-robin grant among the
// input ports, then forwards the owner's flits until a TAIL flit passes.
module osbm_arb #(
  parameter int NIN = 4,
  parameter int DW  = 16,
  parameter int IW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIN-1:0]    req,
  output logic [NIN-1:0]    ack,
  input  logic [NIN-1:0]    empty,
  input  logic [NIN*DW-1:0] din,
  input  logic [NIN*2-1:0]  tin,
  output logic [DW-1:0]     dout,
  output logic [1:0]        tout,
  output logic              vout,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  // state | meaning
  // INIT  | port free; arbitrate and capture the grant-cycle flit
  // XFER  | a packet owns the port until its TAIL flit is captured
  typedef enum logic {INIT = 1'b0, XFER = 1'b1} state_t;

  localparam logic [1:0] TAIL = 2'b11;

  state_t        state, state_nxt;
  logic [IW-1:0] prio;
  logic [IW-1:0] win;
  logic [IW-1:0] cur;
  logic          grant;
  logic          cap;
  logic          last;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NIN);
  endfunction

  // Scan from the highest offset down so the lowest offset from prio wins.
  always_comb begin
    win = '0;
    for (int k = NIN - 1; k >= 0; k--) begin
      if (req[wrap(int'(prio) + k)]) win = wrap(int'(prio) + k);
    end
  end

  always_comb begin
    grant     = (state == INIT) && (|req);
    cur       = (state == INIT) ? win : owner;
    cap       = (grant || (state == XFER)) && !empty[cur];
    last      = cap && (tin[int'(cur)*2 +: 2] == TAIL);
    state_nxt = state;
    case (state)
      INIT: if (grant && !last) state_nxt = XFER;
      XFER: if (last) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
    // Gated by rst so the grant drops the moment reset asserts.
    ack = '0;
    if (grant && !rst) ack[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      prio  <= '0;
      owner <= '0;
      vout  <= 1'b0;
      dout  <= '0;
      tout  <= '0;
    end else begin
      state <= state_nxt;
      vout  <= cap;
      if (grant) owner <= win;
      if (last)  prio  <= wrap(int'(cur) + 1);
      if (cap) begin
        dout <= din[int'(cur)*DW +: DW];
        tout <= tin[int'(cur)*2 +: 2];
      end
    end
  end

  assign busy = (state == XFER);

endmodule

// File: tb/tb_osbm_arb.sv
// Bench for osbm_arb: directed scenarios plus a randomized run against a
// packet-level reference model with per-input FIFO queues.
module tb_osbm_arb;
  localparam int NIN = 4, DW = 16, IW = 2, DEPTH = 256;
  localparam logic [1:0] HEAD = 2'b01, BODY = 2'b10, TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [NIN-1:0] req, ack, empty;
  logic [NIN*DW-1:0] din;
  logic [NIN*2-1:0] tin;
  logic [DW-1:0] dout;
  logic [1:0] tout;
  logic vout, busy;
  logic [IW-1:0] owner;

  always #5 clk = ~clk;

  osbm_arb #(.NIN(NIN), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .empty(empty), .din(din),
    .tin(tin), .dout(dout), .tout(tout), .vout(vout), .busy(busy), .owner(owner)
  );

  logic [17:0] fmem [NIN][DEPTH];
  int rd [NIN];
  int wr [NIN];
  logic [NIN-1:0] req_en, stall;

  int m_prio, m_owner;
  bit m_busy, m_vout;
  logic [15:0] m_dout;
  logic [1:0] m_tout;

  logic [3:0] exp_ack, obs_ack;
  bit exp_vout, exp_busy;
  logic obs_vout, obs_busy;
  logic [15:0] exp_dout, obs_dout;
  logic [1:0] exp_tout, obs_tout;
  int exp_owner;
  logic [IW-1:0] obs_owner;

  int n_tests = 0, n_fail = 0;

  function automatic bit has(int i);
    return rd[i] != wr[i];
  endfunction

  task automatic push(int i, logic [1:0] t, logic [15:0] d);
    fmem[i][wr[i] % DEPTH] = {t, d};
    wr[i]++;
  endtask

  task automatic push_pkt(int i, int len, logic [15:0] base);
    for (int j = 0; j < len; j++)
      push(i, (j == len - 1) ? TAIL : ((j == 0) ? HEAD : BODY), base + 16'(j));
  endtask

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < NIN; k++)
      if (r[(p + k) % NIN]) return (p + k) % NIN;
    return -1;
  endfunction

  task automatic m_reset();
    m_prio = 0; m_owner = 0; m_busy = 0; m_vout = 0; m_dout = '0; m_tout = '0;
    for (int i = 0; i < NIN; i++) begin rd[i] = 0; wr[i] = 0; end
    req_en = '0; stall = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    req = '0; empty = '1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at negedge, snapshot DUT and model, advance model.
  task automatic tick();
    int win, src;
    logic [17:0] f;
    @(negedge clk);
    for (int i = 0; i < NIN; i++) begin
      f = fmem[i][rd[i] % DEPTH];
      empty[i] = !has(i) || stall[i];
      req[i] = req_en[i] && has(i);
      din[i*DW +: DW] = f[15:0];
      tin[i*2 +: 2] = f[17:16];
    end
    #1;
    win = m_busy ? -1 : pick(req, m_prio);
    exp_ack = (win >= 0) ? 4'(1 << win) : 4'b0000;
    exp_vout = m_vout; exp_dout = m_dout; exp_tout = m_tout;
    exp_busy = m_busy; exp_owner = m_owner;
    obs_ack = ack; obs_vout = vout; obs_dout = dout; obs_tout = tout;
    obs_busy = busy; obs_owner = owner;
    @(posedge clk);
    src = m_busy ? m_owner : win;
    m_vout = 0;
    if (src >= 0) begin
      if (!m_busy) begin m_owner = win; m_busy = 1; end
      if (!empty[src]) begin
        f = fmem[src][rd[src] % DEPTH];
        rd[src]++;
        m_vout = 1; m_dout = f[15:0]; m_tout = f[17:16];
        if (f[17:16] == TAIL) begin m_busy = 0; m_prio = (src + 1) % NIN; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; empty = '0; din = '1; tin = '1;
    @(negedge clk); @(negedge clk); #1;
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL reset_vout: got %b expected 0", vout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    n_tests++; if (tout !== 2'b00) begin n_fail++; $display("FAIL reset_tout: got %b expected 00", tout); end
    n_tests++; if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    do_reset();
  endtask

  task automatic test_single_pkt();
    bit v;
    do_reset();
    push_pkt(0, 4, 16'h0010);
    req_en = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      v = (c >= 1 && c <= 4);
      n_tests++; if (obs_ack !== ((c == 0) ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL basic_ack c%0d: got %b", c, obs_ack); end
      n_tests++; if (obs_vout !== v) begin n_fail++; $display("FAIL basic_vout c%0d: got %b expected %b", c, obs_vout, v); end
      n_tests++; if (obs_busy !== (c >= 1 && c <= 3)) begin n_fail++; $display("FAIL basic_busy c%0d: got %b", c, obs_busy); end
      if (v) begin
        n_tests++; if (obs_dout !== 16'h0010 + 16'(c - 1)) begin n_fail++; $display("FAIL basic_dout c%0d: got %h expected %h", c, obs_dout, 16'h0010 + 16'(c - 1)); end
        n_tests++; if (obs_tout !== ((c == 1) ? HEAD : (c == 4) ? TAIL : BODY)) begin n_fail++; $display("FAIL basic_tout c%0d: got %b", c, obs_tout); end
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NIN; i++) push_pkt(i, 2, 16'(i * 256));
    push_pkt(0, 2, 16'h0400);
    req_en = 4'b1111;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_tests++; if ($countones(obs_ack) > 1) begin n_fail++; $display("FAIL rr_onehot c%0d: got %b", c, obs_ack); end
      n_tests++; if (obs_vout !== exp_vout || (exp_vout && (obs_dout !== exp_dout || obs_tout !== exp_tout))) begin
        n_fail++; $display("FAIL rr_stream c%0d: got v%b %h/%b expected v%b %h/%b", c, obs_vout, obs_dout, obs_tout, exp_vout, exp_dout, exp_tout);
      end
      if (obs_ack != 0) order.push_back($clog2(obs_ack));
    end
    n_tests++; if (order.size() != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", order.size()); end
    for (int k = 0; k < 5 && k < order.size(); k++) begin
      n_tests++; if (order[k] != want[k]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], want[k]); end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    push_pkt(2, 5, 16'h2000);
    req_en = 4'b0100;
    tick();
    n_tests++; if (obs_ack !== 4'b0100) begin n_fail++; $display("FAIL bub_grant: got %b expected 0100", obs_ack); end
    push_pkt(0, 2, 16'h0a00); push_pkt(1, 2, 16'h0b00); push_pkt(3, 2, 16'h0d00);
    req_en = 4'b1111;
    tick();
    stall = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_tests++; if (obs_ack !== 4'b0000) begin n_fail++; $display("FAIL bub_ack s%0d: got %b expected 0000", s, obs_ack); end
      n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL bub_busy s%0d: got %b expected 1", s, obs_busy); end
      if (s >= 1) begin
        n_tests++; if (obs_vout !== 1'b0) begin n_fail++; $display("FAIL bub_vout s%0d: got %b expected 0", s, obs_vout); end
      end
    end
    stall = '0;
    tick();
    n_tests++; if (obs_vout !== 1'b0 || obs_busy !== 1'b1) begin n_fail++; $display("FAIL bub_last: got v%b b%b expected v0 b1", obs_vout, obs_busy); end
    tick();
    n_tests++; if (obs_vout !== 1'b1 || obs_dout !== 16'h2002) begin n_fail++; $display("FAIL bub_resume: got v%b %h expected v1 2002", obs_vout, obs_dout); end
  endtask

  task automatic test_single_flit();
    do_reset();
    push(2, TAIL, 16'h5555);
    req_en = 4'b0100;
    tick();
    n_tests++; if (obs_ack !== 4'b0100) begin n_fail++; $display("FAIL sf_setup: got %b expected 0100", obs_ack); end
    tick();
    push(3, TAIL, 16'h3333);
    push_pkt(0, 2, 16'h0a00);
    req_en = 4'b1001;
    tick();
    n_tests++; if (obs_ack !== 4'b1000) begin n_fail++; $display("FAIL sf_ack3: got %b expected 1000", obs_ack); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL sf_busy0: got %b expected 0", obs_busy); end
    tick();
    n_tests++; if (obs_ack !== 4'b0001) begin n_fail++; $display("FAIL sf_next: got %b expected 0001", obs_ack); end
    n_tests++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL sf_busy1: got %b expected 0", obs_busy); end
    n_tests++; if (obs_vout !== 1'b1 || obs_dout !== 16'h3333 || obs_tout !== TAIL) begin
      n_fail++; $display("FAIL sf_flit: got v%b %h/%b expected v1 3333/11", obs_vout, obs_dout, obs_tout);
    end
    tick();
    n_tests++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL sf_busy2: got %b expected 1", obs_busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(1, TAIL, 16'h1111);
    req_en = 4'b0010;
    tick();
    push_pkt(2, 6, 16'h2200);
    req_en = 4'b0100;
    tick(); tick(); tick();
    n_tests++; if (obs_busy !== 1'b1 || obs_vout !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got b%b v%b expected b1 v1", obs_busy, obs_vout); end
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_tests++; if (vout !== 1'b0) begin n_fail++; $display("FAIL ar_vout: got %b expected 0", vout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b expected 0", busy); end
    n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL ar_ack: got %b expected 0000", ack); end
    m_reset();
    req = '0; empty = '1;
    @(negedge clk);
    rst = 1'b0;
    push_pkt(1, 2, 16'h0100);
    push_pkt(2, 2, 16'h0200);
    req_en = 4'b0110;
    tick();
    n_tests++; if (obs_ack !== 4'b0010) begin n_fail++; $display("FAIL ar_prio: got %b expected 0010", obs_ack); end
  endtask

  task automatic test_tail_newreq();
    do_reset();
    push_pkt(0, 2, 16'h0700);
    req_en = 4'b0001;
    tick();
    push_pkt(1, 2, 16'h0800);
    req_en = 4'b0011;
    tick();
    n_tests++; if (obs_ack !== 4'b0000) begin n_fail++; $display("FAIL tn_same: got %b expected 0000", obs_ack); end
    tick();
    n_tests++; if (obs_ack !== 4'b0010) begin n_fail++; $display("FAIL tn_next: got %b expected 0010", obs_ack); end
    n_tests++; if (obs_vout !== 1'b1 || obs_tout !== TAIL || obs_dout !== 16'h0701) begin
      n_fail++; $display("FAIL tn_tail: got v%b %h/%b expected v1 0701/11", obs_vout, obs_dout, obs_tout);
    end
  endtask

  task automatic test_random();
    int i;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        i = $urandom_range(0, NIN - 1);
        if (wr[i] - rd[i] < DEPTH - 8) push_pkt(i, $urandom_range(1, 4), 16'($urandom));
      end
      req_en = 4'($urandom);
      for (int k = 0; k < NIN; k++) stall[k] = ($urandom_range(0, 4) == 0);
      tick();
      n_tests++; if (obs_ack !== exp_ack) begin n_fail++; $display("FAIL rnd_ack c%0d: got %b expected %b", c, obs_ack, exp_ack); end
      n_tests++; if (obs_vout !== exp_vout) begin n_fail++; $display("FAIL rnd_vout c%0d: got %b expected %b", c, obs_vout, exp_vout); end
      n_tests++; if (obs_busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, obs_busy, exp_busy); end
      n_tests++; if (int'(obs_owner) != exp_owner) begin n_fail++; $display("FAIL rnd_owner c%0d: got %0d expected %0d", c, obs_owner, exp_owner); end
      if (exp_vout) begin
        n_tests++; if (obs_dout !== exp_dout || obs_tout !== exp_tout) begin
          n_fail++; $display("FAIL rnd_flit c%0d: got %h/%b expected %h/%b", c, obs_dout, obs_tout, exp_dout, exp_tout);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    m_reset();
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_bubble();
    test_single_flit();
    test_async_reset();
    test_tail_newreq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
